// File: rtl/matmul_pkg.sv
// Shared types and helpers for the outer-product matmul engine:
// FSM states, array-size derivation and signed overflow/saturation helpers.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Widest accumulator sum the helpers can inspect (ACC_WIDTH+1 must fit).
    localparam int unsigned SUM_MAX_W = 129;

    function automatic int unsigned calc_max_dim(int unsigned bus_w, int unsigned data_w);
        return bus_w / data_w;
    endfunction

    function automatic int unsigned calc_dim_w(int unsigned max_dim);
        return (max_dim <= 2) ? 1 : $clog2(max_dim);
    endfunction

    // True when the sign-extended sum does not fit in acc_w signed bits.
    function automatic logic acc_overflow(logic signed [SUM_MAX_W-1:0] sum, int unsigned acc_w);
        logic signed [SUM_MAX_W-1:0] hi;
        hi = sum >>> (acc_w - 1);
        return !((hi == '0) || (&hi));
    endfunction

    function automatic logic [SUM_MAX_W-1:0] acc_saturate(logic signed [SUM_MAX_W-1:0] sum,
                                                          int unsigned acc_w);
        logic [SUM_MAX_W-1:0] min_v;
        min_v = {SUM_MAX_W{1'b1}} << (acc_w - 1);
        return sum[SUM_MAX_W-1] ? min_v : ~min_v;
    endfunction

endpackage

// File: rtl/matmul_mac_pe.sv
// One output-stationary accumulator cell: signed multiply-add with sticky overflow flag.
// Optional clamp on overflow when MATMUL_SATURATE_EN is defined (wraps otherwise).
module matmul_mac_pe
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic                  mask_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [ACC_WIDTH-1:0]  acc_o,
    output logic                  ovf_o
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned SUM_W  = ACC_WIDTH + 1;

    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  sum;
    logic                     ovf;
    logic [ACC_WIDTH-1:0]     acc_q;
    logic [ACC_WIDTH-1:0]     acc_d;
    logic                     flag_q;

    always_comb begin
        prod = PROD_W'($signed(a_i)) * PROD_W'($signed(b_i));
        sum  = SUM_W'($signed(acc_q)) + SUM_W'(prod);
        ovf  = acc_overflow(SUM_MAX_W'(sum), ACC_WIDTH);
`ifdef MATMUL_SATURATE_EN
        acc_d = ovf ? ACC_WIDTH'(acc_saturate(SUM_MAX_W'(sum), ACC_WIDTH)) : ACC_WIDTH'(sum);
`else
        acc_d = ACC_WIDTH'(sum);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            acc_q  <= '0;
            flag_q <= 1'b0;
        end else if (en_i && mask_i) begin
            acc_q <= acc_d;
            if (ovf) begin
                flag_q <= 1'b1;
            end
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = flag_q;

endmodule

// File: rtl/matmul_outer_engine.sv
// Parametrised outer-product matmul engine: one A-column/B-row beat per cycle into a
// MAX_DIM x MAX_DIM MAC array, results drained row by row. Option: MATMUL_SATURATE_EN.
module matmul_outer_engine
    import matmul_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  int unsigned BUS_WIDTH  = 64,
    parameter  int unsigned ACC_WIDTH  = 32,
    localparam int unsigned MAX_DIM    = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
    localparam int unsigned DIM_W      = calc_dim_w(MAX_DIM)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           cfg_valid_i,
    output logic                           cfg_ready_o,
    input  logic [DIM_W-1:0]               cfg_n_i,
    input  logic [DIM_W-1:0]               cfg_k_i,
    input  logic [DIM_W-1:0]               cfg_m_i,
    input  logic                           cfg_mod_i,
    input  logic                           op_valid_i,
    output logic                           op_ready_o,
    input  logic [BUS_WIDTH-1:0]           op_a_i,
    input  logic [BUS_WIDTH-1:0]           op_b_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [MAX_DIM*ACC_WIDTH-1:0]   res_row_o,
    output logic [DIM_W-1:0]               res_row_idx_o,
    output logic                           res_last_o,
    output logic [MAX_DIM*MAX_DIM-1:0]     flags_o,
    output logic                           busy_o
);

    state_e           state_q;
    logic [DIM_W-1:0] n_q, k_q, m_q, beat_q, row_q;
    logic             cfg_ready_q, op_ready_q, res_valid_q, res_last_q, busy_q;

    logic                 cfg_fire, op_fire, clr;
    logic [MAX_DIM-1:0]   row_mask, col_mask;
    logic [ACC_WIDTH-1:0] acc [MAX_DIM][MAX_DIM];

    assign cfg_fire = cfg_valid_i && cfg_ready_q;
    assign op_fire  = op_valid_i && op_ready_q;
    assign clr      = cfg_fire && !cfg_mod_i;

    always_comb begin
        row_mask = '0;
        col_mask = '0;
        for (int i = 0; i < MAX_DIM; i++) begin
            row_mask[i] = (DIM_W'(i) <= n_q);
            col_mask[i] = (DIM_W'(i) <= m_q);
        end
    end

    for (genvar i = 0; i < MAX_DIM; i++) begin : g_row
        for (genvar j = 0; j < MAX_DIM; j++) begin : g_col
            matmul_mac_pe #(
                .DATA_WIDTH(DATA_WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk_i (clk_i),
                .rst_ni(rst_ni),
                .clr_i (clr),
                .en_i  (op_fire),
                .mask_i(row_mask[i] & col_mask[j]),
                .a_i   (op_a_i[i*DATA_WIDTH +: DATA_WIDTH]),
                .b_i   (op_b_i[j*DATA_WIDTH +: DATA_WIDTH]),
                .acc_o (acc[i][j]),
                .ovf_o (flags_o[i*MAX_DIM+j])
            );
        end
    end

    // Row mux straight off the accumulators so the first row is ready right after the last beat.
    always_comb begin
        res_row_o = '0;
        for (int j = 0; j < MAX_DIM; j++) begin
            if (col_mask[j]) begin
                res_row_o[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_q][j];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            k_q         <= '0;
            m_q         <= '0;
            beat_q      <= '0;
            row_q       <= '0;
            cfg_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_fire) begin
                        n_q         <= cfg_n_i;
                        k_q         <= cfg_k_i;
                        m_q         <= cfg_m_i;
                        state_q     <= ST_LOAD;
                        cfg_ready_q <= 1'b0;
                        op_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (op_fire) begin
                        if (beat_q == k_q) begin
                            beat_q      <= '0;
                            state_q     <= ST_DRAIN;
                            op_ready_q  <= 1'b0;
                            res_valid_q <= 1'b1;
                            res_last_q  <= (n_q == '0);
                        end else begin
                            beat_q <= beat_q + DIM_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (res_ready_i) begin
                        if (res_last_q) begin
                            row_q       <= '0;
                            state_q     <= ST_IDLE;
                            res_valid_q <= 1'b0;
                            res_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            cfg_ready_q <= 1'b1;
                        end else begin
                            row_q      <= row_q + DIM_W'(1);
                            res_last_q <= ((row_q + DIM_W'(1)) == n_q);
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cfg_ready_q <= 1'b1;
                    op_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                    res_last_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready_o   = cfg_ready_q;
    assign op_ready_o    = op_ready_q;
    assign res_valid_o   = res_valid_q;
    assign res_last_o    = res_last_q;
    assign res_row_idx_o = row_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_matmul_outer_engine.sv
// Scoreboard bench for matmul_outer_engine: directed vectors, expected rows queued by
// the stimulus and checked by an independent result monitor.
`timescale 1ns/1ps
module tb_matmul_outer_engine;

    localparam int DW = 16;
    localparam int BW = 64;
    localparam int AW = 32;
    localparam int MD = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              cfg_valid_i, cfg_ready_o, cfg_mod_i;
    logic [1:0]        cfg_n_i, cfg_k_i, cfg_m_i;
    logic              op_valid_i, op_ready_o;
    logic [BW-1:0]     op_a_i, op_b_i;
    logic              res_valid_o, res_ready_i, res_last_o, busy_o;
    logic [MD*AW-1:0]  res_row_o;
    logic [1:0]        res_row_idx_o;
    logic [MD*MD-1:0]  flags_o;

    always #5 clk_i = ~clk_i;

    matmul_outer_engine #(
        .DATA_WIDTH(DW),
        .BUS_WIDTH (BW),
        .ACC_WIDTH (AW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_n_i      (cfg_n_i),
        .cfg_k_i      (cfg_k_i),
        .cfg_m_i      (cfg_m_i),
        .cfg_mod_i    (cfg_mod_i),
        .op_valid_i   (op_valid_i),
        .op_ready_o   (op_ready_o),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_row_o    (res_row_o),
        .res_row_idx_o(res_row_idx_o),
        .res_last_o   (res_last_o),
        .flags_o      (flags_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [MD*AW-1:0] row;
        logic [1:0]       idx;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_beats  = 0;

    task automatic check(string name, logic [127:0] act, logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [BW-1:0] p16(int l0, int l1, int l2, int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    function automatic logic [MD*AW-1:0] p32(int l0, int l1, int l2, int l3);
        return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    endfunction

    task automatic push_row(logic [MD*AW-1:0] row, int idx, bit last);
        exp_t x;
        x.row  = row;
        x.idx  = 2'(idx);
        x.last = last;
        exp_q.push_back(x);
    endtask

    // Result monitor: every row handshake pops one expectation.
    always @(negedge clk_i) begin
        if (rst_ni && op_valid_i && op_ready_o) n_beats++;
        if (rst_ni && res_valid_o && res_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_row: got idx %0d, expected no row", res_row_idx_o);
            end else begin
                e = exp_q.pop_front();
                check("row_data", res_row_o, e.row);
                check("row_idx_last", {res_row_idx_o, res_last_o}, {e.idx, e.last});
            end
        end
    end

    task automatic do_cfg(int n, int k, int m, bit mod);
        int t = 0;
        cfg_n_i = 2'(n); cfg_k_i = 2'(k); cfg_m_i = 2'(m); cfg_mod_i = mod;
        cfg_valid_i = 1'b1;
        @(negedge clk_i);
        while (!cfg_ready_o && t < 50) begin t++; @(negedge clk_i); end
        if (!cfg_ready_o) begin
            n_checks++; n_fail++;
            $display("FAIL cfg_timeout: got ready 0, expected 1");
        end
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
    endtask

    task automatic beat(logic [BW-1:0] a, logic [BW-1:0] b, int gap);
        int t = 0;
        op_valid_i = 1'b0;
        repeat (gap) @(posedge clk_i);
        #1;
        op_a_i = a; op_b_i = b; op_valid_i = 1'b1;
        @(negedge clk_i);
        while (!op_ready_o && t < 50) begin t++; @(negedge clk_i); end
        if (!op_ready_o) begin
            n_checks++; n_fail++;
            $display("FAIL op_timeout: got ready 0, expected 1");
        end
        @(posedge clk_i); #1;
        op_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 200) begin t++; @(negedge clk_i); end
        if (exp_q.size() > 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d rows pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk_i); #1;
        check("idle_after_drain", {busy_o, cfg_ready_o}, 2'b01);
    endtask

    // Identity A, B[k][j]=4k+j; expected C = B.
    task automatic ident_load(bit mod, int gap);
        do_cfg(3, 3, 3, mod);
        for (int r = 0; r < 4; r++) push_row(p32(4*r, 4*r+1, 4*r+2, 4*r+3), r, r == 3);
        for (int k = 0; k < 4; k++) beat(64'(1) << (16*k), p16(4*k, 4*k+1, 4*k+2, 4*k+3), gap);
    endtask

    task automatic masked_run(bit mod);
        do_cfg(1, 2, 1, mod);
        if (mod) begin
            push_row(p32(116, 128, 0, 0), 0, 0);
            push_row(p32(278, 308, 0, 0), 1, 1);
        end else begin
            push_row(p32(58, 64, 0, 0), 0, 0);
            push_row(p32(139, 154, 0, 0), 1, 1);
        end
        beat(p16(1, 4, 99, 99), p16(7, 8, 99, 99), 0);
        beat(p16(2, 5, 99, 99), p16(9, 10, 99, 99), 0);
        beat(p16(3, 6, 99, 99), p16(11, 12, 99, 99), 0);
        wait_drain();
    endtask

    initial begin
        int ovf_wrap;
        rst_ni = 1'b0; cfg_valid_i = 1'b0; cfg_n_i = '0; cfg_k_i = '0; cfg_m_i = '0;
        cfg_mod_i = 1'b0; op_valid_i = 1'b0; op_a_i = '0; op_b_i = '0; res_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_ctrl", {cfg_ready_o, busy_o, res_valid_o, op_ready_o, res_last_o, res_row_idx_o},
              7'b1000000);
        check("reset_flags", flags_o, 16'h0);
        rst_ni = 1'b1;

        // 1: identity, plus first-row latency
        ident_load(1'b0, 0);
        check("latency_first_row", res_valid_o, 1'b1);
        wait_drain();
        check("identity_flags", flags_o, 16'h0);

        // 2 and 3: masked 2x3x2, then accumulate onto it
        n_beats = 0;
        masked_run(1'b0);
        check("masked_beat_count", n_beats, 3);
        masked_run(1'b1);
        check("accum_flags", flags_o, 16'h0);

        // 4: overflow on element 0 in the third pass
`ifdef MATMUL_SATURATE_EN
        ovf_wrap = 32'h7FFF_FFFF;
`else
        ovf_wrap = -1073938429;
`endif
        do_cfg(0, 0, 0, 1'b0);
        push_row(p32(1073676289, 0, 0, 0), 0, 1);
        beat(p16(32'h7FFF, 0, 0, 0), p16(32'h7FFF, 0, 0, 0), 0);
        wait_drain();
        check("ovf_pass1_flags", flags_o, 16'h0);
        do_cfg(0, 0, 0, 1'b1);
        push_row(p32(2147352578, 0, 0, 0), 0, 1);
        beat(p16(32'h7FFF, 0, 0, 0), p16(32'h7FFF, 0, 0, 0), 0);
        wait_drain();
        check("ovf_pass2_flags", flags_o, 16'h0);
        do_cfg(0, 0, 0, 1'b1);
        push_row(p32(ovf_wrap, 0, 0, 0), 0, 1);
        beat(p16(32'h7FFF, 0, 0, 0), p16(32'h7FFF, 0, 0, 0), 0);
        wait_drain();
        check("ovf_pass3_flags", flags_o, 16'h0001);

        // 5: operand gaps and result backpressure
        res_ready_i = 1'b0;
        ident_load(1'b0, 2);
        repeat (5) begin
            @(negedge clk_i);
            check("hold_row", {res_valid_o, res_row_idx_o, res_row_o}, {1'b1, 2'd0, p32(0, 1, 2, 3)});
        end
        res_ready_i = 1'b1;
        wait_drain();
        check("gap_flags_cleared", flags_o, 16'h0);

        // 6: reset after two of four beats, then accumulate-mode identity must be clean
        do_cfg(3, 3, 3, 1'b0);
        beat(p16(1, 0, 0, 0), p16(0, 1, 2, 3), 0);
        beat(p16(0, 1, 0, 0), p16(4, 5, 6, 7), 0);
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        check("midload_reset", {busy_o, cfg_ready_o, op_ready_o, res_valid_o}, 4'b0100);
        ident_load(1'b1, 0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200us");
        $fatal(1, "watchdog");
    end

endmodule
